conv1_seq_ctrl: RTL and testbench
=================================

# conv1_seq_ctrl

Address sequencer and control FSM for convolution layer 1. On a start pulse it walks every output channel, output position and kernel tap, and drives the read addresses of the conv1 weight, input-activation and bias ROMs. It also emits data-aligned qualifiers (`bias_valid`, `tap_valid`, `acc_clr`, `acc_last`) so the layer-1 MAC/ReLU datapath can accumulate without its own counters. The block sits beside the three ROMs inside the layer-1 wrapper, and its `end_mod` is the layer's completion signal.

## Interface
- `n`, 512: activation length (ROM words).
- `k`, 32: kernel taps per channel.
- `step`, 8: stride between output positions.
- `outlen`, 61: outputs per channel; must equal (n-k)/step+1.
- `channelnb`, 4: output channels.
- `clk` in 1: single clock, rising edge.
- `global_rst` in 1: **reset is synchronous and active-high**; single clock domain `clk`.
- `ce` in 1: clock enable. When low, all state, addresses and qualifiers hold.
- `start` in 1: run request. Sampled only in IDLE with `ce`=1.
- `busy` out 1: high from the cycle after `start` is accepted until `end_mod`, inclusive.
- `weight_addr` out $clog2(channelnb*k): equals ch*k+t.
- `act_addr` out $clog2(n): equals o*step+t.
- `bias_addr` out $clog2(channelnb): equals ch.
- `bias_valid` out 1: bias ROM `douta` is valid this cycle.
- `tap_valid` out 1: weight and activation `douta` are valid this cycle.
- `acc_clr` out 1: with `tap_valid`; this is tap t=0, so the accumulator loads instead of adding.
- `acc_last` out 1: with `tap_valid`; this is tap t=k-1, and the result is complete next cycle.
- `out_idx` out $clog2(outlen): o of the data currently qualified.
- `ch_idx` out $clog2(channelnb): ch of the data currently qualified.
- `end_mod` out 1: one-cycle pulse when the last tap's data has been qualified.

## Operation
- FSM states: IDLE, BIAS, RUN, DRAIN, DONE.
- IDLE → BIAS on `start`&`ce`. Counters ch, o and t are cleared.
- BIAS: issue `bias_addr`=ch for one cycle, then go to RUN.
- RUN: issue one tap per `ce` cycle, with t innermost, then o, then ch.
  - At t=k-1 and o<outlen-1: o increments and t returns to 0.
  - At t=k-1, o=outlen-1 and ch<channelnb-1: ch increments, o returns to 0, next state BIAS.
  - At t=k-1, o=outlen-1 and ch=channelnb-1: next state DRAIN.
- DRAIN: one cycle so the last ROM read can return. Then go to DONE.
- DONE: assert `end_mod` for one cycle, then return to IDLE.
- ROM read latency is fixed at 1 `ce` cycle. Every qualifier and index is the issue-cycle value delayed through a 1-stage pipe that advances only on `ce`.
- `start` asserted while busy is ignored. There is no queueing.
- Counter widths follow the port widths. No counter wraps past its bound, because terminal compares use the exact values k-1, outlen-1 and channelnb-1.
- Reset, including mid-run:
  - FSM returns to IDLE and all counters clear.
  - All outputs go to 0 on the next edge: `busy`, qualifiers, `end_mod`, addresses, `out_idx`, `ch_idx`.
  - The pipe stage is flushed, so no stale `tap_valid` appears.

## Timing
- Start to first `bias_valid` is 2 cycles. The first `tap_valid` follows 1 cycle later.
- One bias cycle plus outlen·k tap cycles per channel gives 4·(1+61·32)=7812 issue cycles at defaults.
- Total from `start` to `end_mod` is 7812+3 = 7815 cycles, assuming `ce` stays high.
- Cycles with `ce` low extend the latency 1:1 and produce no qualifier pulses.
- `acc_last` and `tap_valid` for the final tap come 2 cycles before `end_mod`.

## Configuration
- `CONV1_SEQ_BIAS_EN` defined: the BIAS state exists and `bias_valid` pulses once per channel.
- Not defined:
  - BIAS is skipped and IDLE/channel change go straight to RUN.
  - `bias_addr` and `bias_valid` are tied to 0.
  - Total latency at defaults is 7811 cycles.

## Structure
- Shared package `conv1_pkg` holds the FSM state enum and the default layer constants (512, 32, 8, 61, 4). `convlay1` and this block both import it.
- One sub-module, `conv1_rd_pipe`: the `ce`-gated 1-stage delay for the qualifiers and indices. Its depth is parameterized in case ROM latency changes.

## Test plan
- Reset, then `start` with `ce`=1. Required:
  - `end_mod` exactly 7815 cycles after `start`.
  - Exactly 4 `bias_valid`, 7808 `tap_valid`, 244 `acc_clr` and 244 `acc_last` pulses.
- Address check:
  - At ch=2, o=5, t=3: `weight_addr`=67 and `act_addr`=43.
  - The last issue has `act_addr`=511 and `weight_addr`=127.
- `ce` toggled 50% in a pseudo-random pattern. Required:
  - The address sequence is identical to the `ce`=1 run.
  - `tap_valid` is never high while `ce`=0.
  - Latency equals 7815 plus the number of `ce`-low cycles.
- `global_rst` asserted at cycle 1000 of a run. Required:
  - All outputs are 0 on the next cycle and `busy`=0.
  - A new `start` gives a clean full run with correct counts.
- `start` held high for the whole run. Required:
  - Exactly one run.
  - A second run begins only after returning to IDLE, with `busy` low for ≥1 cycle between runs.
- Build without `CONV1_SEQ_BIAS_EN`. Required:
  - `bias_valid` is never asserted.
  - `end_mod` occurs 7811 cycles after `start`.

Source files
------------

// File: rtl/conv1_pkg.sv
// Shared constants and FSM state type for convolution layer 1.
// Imported by the layer-1 wrapper and by the address sequencer.
package conv1_pkg;

    localparam int conv1_n         = 512;
    localparam int conv1_k         = 32;
    localparam int conv1_step      = 8;
    localparam int conv1_outlen    = 61;
    localparam int conv1_channelnb = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } conv1_state_t;

    // Keeps every derived bus at least one bit wide for degenerate sizes.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/conv1_rd_pipe.sv
// ce-gated delay line that aligns issue-side qualifiers and indices with ROM read data.
// depth matches the ROM read latency in ce cycles.
module conv1_rd_pipe #(
    parameter int width = 8,
    parameter int depth = 1
) (
    input  logic             clk,
    input  logic             global_rst,
    input  logic             ce,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] stage [depth];

    always_ff @(posedge clk) begin
        if (global_rst) begin
            for (int i = 0; i < depth; i++) begin
                stage[i] <= '0;
            end
        end else if (ce) begin
            stage[0] <= d;
            for (int i = 1; i < depth; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[depth-1];

endmodule

// File: rtl/conv1_seq_ctrl.sv
// Address sequencer and control FSM for conv layer 1 (channel / output / tap walk).
// Optional build macro CONV1_SEQ_BIAS_EN adds a one-cycle bias fetch per channel.
module conv1_seq_ctrl
    import conv1_pkg::*;
#(
    parameter int n         = conv1_n,
    parameter int k         = conv1_k,
    parameter int step      = conv1_step,
    parameter int outlen    = conv1_outlen,
    parameter int channelnb = conv1_channelnb,
    parameter int rd_lat    = 1
) (
    input  logic                                 clk,
    input  logic                                 global_rst,
    input  logic                                 ce,
    input  logic                                 start,
    output logic                                 busy,
    output logic [clog2_min1(channelnb*k)-1:0]   weight_addr,
    output logic [clog2_min1(n)-1:0]             act_addr,
    output logic [clog2_min1(channelnb)-1:0]     bias_addr,
    output logic                                 bias_valid,
    output logic                                 tap_valid,
    output logic                                 acc_clr,
    output logic                                 acc_last,
    output logic [clog2_min1(outlen)-1:0]        out_idx,
    output logic [clog2_min1(channelnb)-1:0]     ch_idx,
    output logic                                 end_mod,
    output conv1_state_t                         dbg_state
);

    localparam int waw = clog2_min1(channelnb*k);
    localparam int aaw = clog2_min1(n);
    localparam int tw  = clog2_min1(k);
    localparam int ow  = clog2_min1(outlen);
    localparam int cw  = clog2_min1(channelnb);

    localparam logic [tw-1:0] t_last  = tw'(k-1);
    localparam logic [ow-1:0] o_last  = ow'(outlen-1);
    localparam logic [cw-1:0] ch_last = cw'(channelnb-1);

`ifdef CONV1_SEQ_BIAS_EN
    localparam conv1_state_t ch_entry = ST_BIAS;
    localparam int pw = 5 + ow + cw;
`else
    localparam conv1_state_t ch_entry = ST_RUN;
    localparam int pw = 4 + ow + cw;
`endif

    conv1_state_t    state_q, state_d;
    logic [tw-1:0]   t_q, t_d;
    logic [ow-1:0]   o_q, o_d;
    logic [cw-1:0]   ch_q, ch_d;
    logic            accept;

    // Issue stage: registered ROM addresses plus the flags describing that read.
    logic            iss_tap, iss_clr, iss_last, iss_end;
    logic [ow-1:0]   iss_o;
    logic [cw-1:0]   iss_ch;
    logic            tap_q, clr_q, last_q, end_q;
    logic [pw-1:0]   pipe_d, pipe_q;

    assign accept = (state_q == ST_IDLE) && start && !busy;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        o_d     = o_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    t_d     = '0;
                    o_d     = '0;
                    ch_d    = '0;
                    state_d = ch_entry;
                end
            end
            ST_BIAS: state_d = ST_RUN;
            ST_RUN: begin
                if (t_q == t_last) begin
                    t_d = '0;
                    if (o_q == o_last) begin
                        o_d = '0;
                        if (ch_q == ch_last) begin
                            state_d = ST_DRAIN;
                        end else begin
                            ch_d    = ch_q + 1'b1;
                            state_d = ch_entry;
                        end
                    end else begin
                        o_d = o_q + 1'b1;
                    end
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            o_q     <= '0;
            ch_q    <= '0;
        end else if (ce) begin
            state_q <= state_d;
            t_q     <= t_d;
            o_q     <= o_d;
            ch_q    <= ch_d;
        end
    end

    // busy spans acceptance through the end_mod cycle; IDLE ignores start until it drops.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            busy <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                busy <= 1'b1;
            end else if (end_q) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            weight_addr <= '0;
            act_addr    <= '0;
            iss_tap     <= 1'b0;
            iss_clr     <= 1'b0;
            iss_last    <= 1'b0;
            iss_end     <= 1'b0;
            iss_o       <= '0;
            iss_ch      <= '0;
        end else if (ce) begin
            weight_addr <= waw'(int'(ch_q) * k + int'(t_q));
            act_addr    <= aaw'(int'(o_q) * step + int'(t_q));
            iss_tap     <= (state_q == ST_RUN);
            iss_clr     <= (state_q == ST_RUN) && (t_q == '0);
            iss_last    <= (state_q == ST_RUN) && (t_q == t_last);
            iss_end     <= (state_q == ST_DONE);
            iss_o       <= o_q;
            iss_ch      <= ch_q;
        end
    end

`ifdef CONV1_SEQ_BIAS_EN
    logic iss_bias, bias_q;

    always_ff @(posedge clk) begin
        if (global_rst) begin
            bias_addr <= '0;
            iss_bias  <= 1'b0;
        end else if (ce) begin
            bias_addr <= ch_q;
            iss_bias  <= (state_q == ST_BIAS);
        end
    end

    assign pipe_d = {iss_bias, iss_tap, iss_clr, iss_last, iss_end, iss_o, iss_ch};
    assign {bias_q, tap_q, clr_q, last_q, end_q, out_idx, ch_idx} = pipe_q;
    assign bias_valid = bias_q & ce;
`else
    assign pipe_d = {iss_tap, iss_clr, iss_last, iss_end, iss_o, iss_ch};
    assign {tap_q, clr_q, last_q, end_q, out_idx, ch_idx} = pipe_q;
    assign bias_addr  = '0;
    assign bias_valid = 1'b0;
`endif

    conv1_rd_pipe #(
        .width (pw),
        .depth (rd_lat)
    ) u_rd_pipe (
        .clk        (clk),
        .global_rst (global_rst),
        .ce         (ce),
        .d          (pipe_d),
        .q          (pipe_q)
    );

    // Qualifiers only pulse on ce cycles, so the datapath never consumes during a stall.
    assign tap_valid = tap_q  & ce;
    assign acc_clr   = clr_q  & ce;
    assign acc_last  = last_q & ce;
    assign end_mod   = end_q  & ce;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv1_seq_ctrl.sv
// Bench for conv1_seq_ctrl: randomized ce against a nested-loop walk model and a 1-cycle ROM model.
module tb_conv1_seq_ctrl;
    import conv1_pkg::*;

    localparam int k         = conv1_k;
    localparam int step      = conv1_step;
    localparam int outlen    = conv1_outlen;
    localparam int channelnb = conv1_channelnb;
`ifdef CONV1_SEQ_BIAS_EN
    localparam int bias_cycles = 1;
`else
    localparam int bias_cycles = 0;
`endif
    localparam int n_taps       = channelnb * outlen * k;
    localparam int issue_cycles = channelnb * (bias_cycles + outlen * k);
    localparam int base_lat     = issue_cycles + 3;
    localparam int cycle_budget = 30000;

    logic clk = 1'b0;
    logic global_rst, ce, start;
    logic busy, bias_valid, tap_valid, acc_clr, acc_last, end_mod;
    logic [$clog2(channelnb*k)-1:0] weight_addr;
    logic [$clog2(conv1_n)-1:0]     act_addr;
    logic [$clog2(channelnb)-1:0]   bias_addr;
    logic [$clog2(outlen)-1:0]      out_idx;
    logic [$clog2(channelnb)-1:0]   ch_idx;
    conv1_state_t                   dbg_state;

    logic [$clog2(channelnb*k)-1:0] rom_w;
    logic [$clog2(conv1_n)-1:0]     rom_a;
    logic [$clog2(channelnb)-1:0]   rom_b;

    int checks   = 0;
    int failures = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  exp_bias_q[$];

    conv1_seq_ctrl dut (
        .clk         (clk),
        .global_rst  (global_rst),
        .ce          (ce),
        .start       (start),
        .busy        (busy),
        .weight_addr (weight_addr),
        .act_addr    (act_addr),
        .bias_addr   (bias_addr),
        .bias_valid  (bias_valid),
        .tap_valid   (tap_valid),
        .acc_clr     (acc_clr),
        .acc_last    (acc_last),
        .out_idx     (out_idx),
        .ch_idx      (ch_idx),
        .end_mod     (end_mod),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Identity ROMs with one ce-cycle read latency.
    always @(posedge clk) begin
        if (ce) begin
            rom_w <= weight_addr;
            rom_a <= act_addr;
            rom_b <= bias_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},        32'(busy), 0);
        chk({tag, "_weight_addr"}, 32'(weight_addr), 0);
        chk({tag, "_act_addr"},    32'(act_addr), 0);
        chk({tag, "_bias_addr"},   32'(bias_addr), 0);
        chk({tag, "_bias_valid"},  32'(bias_valid), 0);
        chk({tag, "_tap_valid"},   32'(tap_valid), 0);
        chk({tag, "_acc_clr"},     32'(acc_clr), 0);
        chk({tag, "_acc_last"},    32'(acc_last), 0);
        chk({tag, "_out_idx"},     32'(out_idx), 0);
        chk({tag, "_ch_idx"},      32'(ch_idx), 0);
        chk({tag, "_end_mod"},     32'(end_mod), 0);
        chk({tag, "_state"},       32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Expected walk: ch outermost, then o, then t; one bias read per channel when enabled.
    task automatic load_model();
        exp_q.delete();
        exp_bias_q.delete();
        for (int c = 0; c < channelnb; c++) begin
            if (bias_cycles != 0) exp_bias_q.push_back(8'(c));
            for (int o = 0; o < outlen; o++)
                for (int t = 0; t < k; t++)
                    exp_q.push_back({8'(c), 8'(o), 8'(t)});
        end
    endtask

    task automatic run_one(input string tag, input bit rand_ce, input bit hold_start, input int abort_at);
        int cyc, nlow, n_tap, n_bias, n_clr, n_last, ec, eo, et;
        bit seen_end;
        logic [23:0] e;
        load_model();
        start = 1'b1;
        ce    = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_after_start"}, 32'(busy), 1);
        start = hold_start;
        ce    = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
        nlow  = (ce == 1'b0) ? 1 : 0;
        cyc = 0; n_tap = 0; n_bias = 0; n_clr = 0; n_last = 0; seen_end = 1'b0;
        while (!seen_end && cyc < cycle_budget) begin
            @(posedge clk); #1;
            cyc++;
            if (abort_at != 0 && cyc == abort_at) begin
                global_rst = 1'b1;
                @(posedge clk); #1;
                check_zero({tag, "_midrun_rst"});
                global_rst = 1'b0;
                start      = 1'b0;
                ce         = 1'b1;
                @(posedge clk); #1;
                return;
            end
            chk({tag, "_tap_while_ce_low"}, 32'(tap_valid & ~ce), 0);
            if (acc_clr)  n_clr++;
            if (acc_last) n_last++;
            if (tap_valid) begin
                n_tap++;
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra_tap"}, 32'(n_tap), n_taps);
                end else begin
                    e  = exp_q.pop_front();
                    ec = int'(e[23:16]);
                    eo = int'(e[15:8]);
                    et = int'(e[7:0]);
                    chk({tag, "_weight_addr"}, 32'(rom_w), 32'(ec * k + et));
                    chk({tag, "_act_addr"},    32'(rom_a), 32'(eo * step + et));
                    chk({tag, "_ch_idx"},      32'(ch_idx), 32'(ec));
                    chk({tag, "_out_idx"},     32'(out_idx), 32'(eo));
                    chk({tag, "_acc_clr"},     32'(acc_clr), 32'(et == 0));
                    chk({tag, "_acc_last"},    32'(acc_last), 32'(et == k - 1));
                    if (ec == 2 && eo == 5 && et == 3) begin
                        chk({tag, "_spot_weight_67"}, 32'(rom_w), 67);
                        chk({tag, "_spot_act_43"},    32'(rom_a), 43);
                    end
                    if (exp_q.size() == 0) begin
                        chk({tag, "_last_act_511"},    32'(rom_a), 511);
                        chk({tag, "_last_weight_127"}, 32'(rom_w), 127);
                    end
                end
            end
            if (bias_valid) begin
                n_bias++;
                if (exp_bias_q.size() == 0) chk({tag, "_extra_bias"}, 32'(n_bias), 32'(channelnb * bias_cycles));
                else chk({tag, "_bias_addr"}, 32'(rom_b), 32'(exp_bias_q.pop_front()));
            end
            if (end_mod) begin
                seen_end = 1'b1;
                chk({tag, "_latency"},       32'(cyc), 32'(base_lat + nlow));
                chk({tag, "_busy_at_end"},   32'(busy), 1);
            end else begin
                chk({tag, "_busy_in_run"}, 32'(busy), 1);
                ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!ce) nlow++;
            end
        end
        chk({tag, "_end_seen"},    32'(seen_end), 1);
        chk({tag, "_n_tap"},       32'(n_tap), n_taps);
        chk({tag, "_n_bias"},      32'(n_bias), 32'(channelnb * bias_cycles));
        chk({tag, "_n_clr"},       32'(n_clr), 32'(channelnb * outlen));
        chk({tag, "_n_last"},      32'(n_last), 32'(channelnb * outlen));
        chk({tag, "_taps_left"},   32'(exp_q.size()), 0);
        ce = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_after_end"}, 32'(busy), 0);
        chk({tag, "_end_one_cycle"},  32'(end_mod), 0);
        if (hold_start) begin
            @(posedge clk); #1;
            chk({tag, "_second_run_starts"}, 32'(busy), 1);
            start      = 1'b0;
            global_rst = 1'b1;
            @(posedge clk); #1;
            global_rst = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        global_rst = 1'b1;
        ce         = 1'b1;
        start      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        global_rst = 1'b0;
        @(posedge clk); #1;

        run_one("full_ce1", 1'b0, 1'b0, 0);
        run_one("rand_ce",  1'b1, 1'b0, 0);
        run_one("abort",    1'b0, 1'b0, 1000);
        run_one("after_rst", 1'b0, 1'b0, 0);
        run_one("hold_start", 1'b0, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
